uart_rx_oversampled: RTL and testbench

- UART receiver that consumes a single-cycle clock-enable tick at OVERSAMPLE x baud from the team's clock divider.
- Samples an asynchronous serial line and recovers 8N1 frames.
- Presents each byte with a one-clk valid strobe to downstream logic, e.g. the LED command decoder.
- Sits between the FPGA rx pin and the command parser; all timing derives from the tick, never from free-running counts of clk.

---
 rtl/uart_rx_oversampled.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: recovers DATA_BITS-N-1 frames using a tick at OVERSAMPLE x baud.
// Defining UART_RX_PARITY_EN adds an even-parity bit before the stop bit and a parity_err output.
module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_s_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   par_q, par_d;
  logic                   perr_q, perr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      par_q     <= par_d;
      perr_q    <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    par_d   = par_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          // Start bit must still be low at its midpoint, else it was a glitch.
          if (cnt_q == CNT_HALF) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_MAX) begin
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            cnt_d   = '0;
            idx_d   = idx_q + IW'(1);
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == CNT_MAX) begin
            par_d   = rx_s_q;
            cnt_d   = '0;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`endif
        S_STOP: begin
          // Returning to IDLE at the stop midpoint lets a back-to-back start bit be caught.
          if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (rx_s_q) begin
              state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (^{shreg_q, par_q}) begin
                perr_d = 1'b1;
              end else begin
                data_d  = shreg_q;
                valid_d = 1'b1;
              end
`else
              data_d  = shreg_q;
              valid_d = 1'b1;
`endif
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_BREAK: begin
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  logic unused_par;
  assign unused_par = par_q ^ perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: 8 data bits, 16x oversample, tick every 4 clk (bit = 64 clk).
module tb_uart_rx_oversampled;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int errors = 0;
  int checks = 0;

  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int perr_cnt  = 0;
  int both_cnt  = 0;
  logic [7:0] vlog[$];
  int tcnt = 0;

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (tcnt == 3);
      tcnt = (tcnt + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        valid_cnt++;
        vlog.push_back(data);
      end
      if (frame_err) ferr_cnt++;
      if (valid && frame_err) both_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) perr_cnt++;
      if (parity_err && (valid || frame_err)) both_cnt++;
`endif
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Parity bit is only put on the line when the DUT is built with parity.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par);
    rx = 1'b0;
    wait_clks(64);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(64);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    wait_clks(64);
`else
    if (par === 1'bx) rx = 1'b1;
`endif
    rx = stop_bit;
    wait_clks(64);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    wait_clks(5);
    if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    rst = 1'b0;
    wait_clks(20);
  endtask

  task automatic test_single;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b1, 1'b0);
    wait_clks(64);
    if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL single_valid_count: got %0d expected 1", valid_cnt - v0); end
    checks++;
    if (vlog.size() > v0 && vlog[v0] !== 8'h55) begin errors++; $display("FAIL single_logged_data: got %h expected 55", vlog[v0]); end
    checks++;
    if (data !== 8'h55) begin errors++; $display("FAIL single_data: got %h expected 55", data); end
    checks++;
    if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL single_frame_err: got %0d expected 0", ferr_cnt - f0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    checks++;
  endtask

  task automatic test_back_to_back;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    wait_clks(128);
    if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 2", valid_cnt - v0); end
    checks++;
    if (vlog.size() > v0 && vlog[v0] !== 8'hA3) begin errors++; $display("FAIL b2b_first: got %h expected a3", vlog[v0]); end
    checks++;
    if (vlog.size() > v0 + 1 && vlog[v0+1] !== 8'h0F) begin errors++; $display("FAIL b2b_second: got %h expected 0f", vlog[v0+1]); end
    checks++;
    if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL b2b_frame_err: got %0d expected 0", ferr_cnt - f0); end
    checks++;
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    wait_clks(12);
    if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_during: got %b expected 1", busy); end
    checks++;
    wait_clks(8);
    rx = 1'b1;
    wait_clks(200);
    if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", valid_cnt - v0); end
    checks++;
    if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_frame_err: got %0d expected 0", ferr_cnt - f0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after: got %b expected 0", busy); end
    checks++;
  endtask

  task automatic test_break;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hFF, 1'b0, 1'b0);
    rx = 1'b0;
    wait_clks(30 * 64);
    if (busy !== 1'b1) begin errors++; $display("FAIL break_busy_held: got %b expected 1", busy); end
    checks++;
    rx = 1'b1;
    wait_clks(128);
    if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL break_frame_err_count: got %0d expected 1", ferr_cnt - f0); end
    checks++;
    if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL break_valid: got %0d expected 0", valid_cnt - v0); end
    checks++;
    if (data !== 8'h0F) begin errors++; $display("FAIL break_data_kept: got %h expected 0f", data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL break_busy_after: got %b expected 0", busy); end
    checks++;
    send_frame(8'h12, 1'b1, 1'b0);
    wait_clks(64);
    if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL after_break_valid: got %0d expected 1", valid_cnt - v0); end
    checks++;
    if (data !== 8'h12) begin errors++; $display("FAIL after_break_data: got %h expected 12", data); end
    checks++;
  endtask

  task automatic test_reset_midframe;
    int v0, f0;
    logic [7:0] d;
    d = 8'h3C;
    rx = 1'b0;
    wait_clks(64);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_clks(64);
    end
    rx = d[4];
    wait_clks(32);
    rst = 1'b1;
    wait_clks(1);
    if (data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++;
    if (valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL midrst_pulses: got valid=%b frame_err=%b expected 0 0", valid, frame_err);
    end
    checks++;
    rx = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    v0 = valid_cnt; f0 = ferr_cnt;
    wait_clks(700);
    if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin
      errors++; $display("FAIL midrst_no_output: got valid=%0d frame_err=%0d expected 0 0", valid_cnt - v0, ferr_cnt - f0);
    end
    checks++;
    send_frame(8'hC3, 1'b1, 1'b0);
    wait_clks(64);
    if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL midrst_next_valid: got %0d expected 1", valid_cnt - v0); end
    checks++;
    if (data !== 8'hC3) begin errors++; $display("FAIL midrst_next_data: got %h expected c3", data); end
    checks++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0;
    v0 = valid_cnt; p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    wait_clks(64);
    if (perr_cnt - p0 !== 1) begin errors++; $display("FAIL parity_bad_perr: got %0d expected 1", perr_cnt - p0); end
    checks++;
    if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL parity_bad_valid: got %0d expected 0", valid_cnt - v0); end
    checks++;
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clks(64);
    if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL parity_good_valid: got %0d expected 1", valid_cnt - v0); end
    checks++;
    if (data !== 8'h07) begin errors++; $display("FAIL parity_good_data: got %h expected 07", data); end
    checks++;
    if (perr_cnt - p0 !== 1) begin errors++; $display("FAIL parity_good_perr: got %0d expected 1", perr_cnt - p0); end
    checks++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_break;
    test_reset_midframe;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    if (both_cnt !== 0) begin errors++; $display("FAIL exclusive_pulses: got %0d overlaps expected 0", both_cnt); end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
